// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_defs: shared definitions for the MAC sequencer slice.
//   - state_t      : FSM state encoding (IDLE / RUN / DONE)
//   - DEFAULT_*    : default datapath widths and dot-product length
//   - step_width() : width of the pair-index counter for a given length
//   - prod_width() : width of the exact (bw+1) x bw signed product
package mac_seq_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_BW      = 4;
    localparam int DEFAULT_PSUM_BW = 16;
    localparam int DEFAULT_LEN     = 4;

    // One extra bit so the counter can hold len itself after the last MAC.
    function automatic int step_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Activation is widened to bw+1 (signed), weight is bw; the exact
    // product therefore needs (bw+1)+bw bits.
    function automatic int prod_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_mac_core.sv
// mac_core: purely combinational multiply-accumulate, out = a*b + c.
//   a   : unsigned activation, bw bits
//   b   : two's-complement weight, bw bits
//   c   : accumulator input, psum_bw bits
//   out : a*b + c, wrapping modulo 2^psum_bw
// The activation is zero-extended by one bit and treated as signed so the
// product of an unsigned and a signed operand is exact. The product is then
// sign-extended to psum_bw bits before the add.
module mac_core
    import mac_seq_defs::*;
#(
    parameter int bw      = DEFAULT_BW,
    parameter int psum_bw = DEFAULT_PSUM_BW
) (
    input  logic [bw-1:0]        a,
    input  logic signed [bw-1:0] b,
    input  logic [psum_bw-1:0]   c,
    output logic [psum_bw-1:0]   out
);

    localparam int PW = prod_width(bw);

    logic signed [bw:0]         a_s;
    logic signed [PW-1:0]       prod;
    logic signed [psum_bw-1:0]  prod_ext;

    assign a_s      = $signed({1'b0, a});
    assign prod     = PW'(a_s) * PW'(b);
    assign prod_ext = psum_bw'(prod);
    assign out      = $unsigned(prod_ext) + c;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: computes one len-element dot product on a single shared MAC.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (x_vec, w_vec, psum_in)
//   x_vec               : len unsigned activations, lane k = [k*bw +: bw]
//   w_vec               : len signed weights,      lane k = [k*bw +: bw]
//   psum_in             : initial accumulator value
//   out_valid/out_ready : result handshake (psum_out)
//   psum_out            : accumulated result
//   busy                : high in RUN or DONE
//   step                : current pair index in RUN, 0 otherwise
//   dbg_state           : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until that edge;
// ready never depends combinationally on valid. in_ready is high only in
// IDLE, out_valid only in DONE, so an input and an output transfer can never
// share an edge.
module mac_seq_ctrl
    import mac_seq_defs::*;
#(
    parameter int bw      = DEFAULT_BW,
    parameter int psum_bw = DEFAULT_PSUM_BW,
    parameter int len     = DEFAULT_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [len*bw-1:0]     x_vec,
    input  logic [len*bw-1:0]     w_vec,
    input  logic [psum_bw-1:0]    psum_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [psum_bw-1:0]    psum_out,
    output logic                  busy,
    output logic [$clog2(len):0]  step,
    output state_t                dbg_state
);

    localparam int             SW   = step_width(len);
    localparam logic [SW-1:0]  LAST = SW'(len - 1);

    state_t               state_q, state_d;
    logic [len*bw-1:0]    x_q, x_d;
    logic [len*bw-1:0]    w_q, w_d;
    logic [psum_bw-1:0]   acc_q, acc_d;
    logic [SW-1:0]        step_q, step_d;

    logic                 accept;
    logic [bw-1:0]        a_sel;
    logic signed [bw-1:0] b_sel;
    logic [psum_bw-1:0]   mac_out;

    assign accept = in_valid && (state_q == ST_IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)          state_d = ST_RUN;
            ST_RUN:  if (step_q == LAST)  state_d = ST_DONE;
            ST_DONE: if (out_ready)       state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        step      = (state_q == ST_RUN) ? step_q : '0;
        psum_out  = acc_q;
        dbg_state = state_q;
    end

    // Lane select for the shared MAC, driven by the pair index.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < len; k++) begin
            if (step_q == SW'(k)) begin
                a_sel = x_q[k*bw +: bw];
                b_sel = w_q[k*bw +: bw];
            end
        end
    end

    mac_core #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a   (a_sel),
        .b   (b_sel),
        .c   (acc_q),
        .out (mac_out)
    );

    // Operands are only loaded on acceptance, so they stay frozen through
    // RUN and DONE regardless of what the producer drives afterwards.
    always_comb begin
        x_d    = x_q;
        w_d    = w_q;
        acc_d  = acc_q;
        step_d = step_q;
        if (accept) begin
            x_d    = x_vec;
            w_d    = w_vec;
            acc_d  = psum_in;
            step_d = '0;
        end else if (state_q == ST_RUN) begin
            acc_d  = mac_out;
            step_d = step_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            w_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            x_q    <= x_d;
            w_q    <= w_d;
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that computes one dot product of `len` (activation, weight) pairs on a single time-shared MAC datapath.
- Activations are unsigned and weights are signed, as in the existing MAC block.
- Accepts a packed vector with a valid/ready handshake and issues one MAC per cycle, accumulating onto an initial partial sum.
- Returns the final psum with a valid/ready handshake. Sits between the operand buffers and the psum writeback path.

Parameters:
- bw, 4, activation and weight width in bits
- psum_bw, 16, partial-sum width in bits
- len, 4, pairs per dot product (len >= 1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand vector valid
- in_ready  out  1  block can accept a vector
- x_vec  in  len*bw  activations, lane k = bits [k*bw +: bw], unsigned
- w_vec  in  len*bw  weights, lane k = bits [k*bw +: bw], two's complement
- psum_in  in  psum_bw  initial accumulator value
- out_valid  out  1  psum_out holds a finished result
- out_ready  in  1  consumer accepts result
- psum_out  out  psum_bw  accumulated result
- busy  out  1  high in RUN or DONE
- step  out  clog2(len)+1  current pair index in RUN, 0 otherwise

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE
  - in_ready = 1, out_valid = 0, busy = 0, step = 0
  - psum_out = 0 and accumulator = 0
  - operand registers = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: latch x_vec and w_vec, set acc <= psum_in, step <= 0, move to RUN.
  - in_valid without in_ready has no effect.
- RUN:
  - in_ready = 0.
  - Each edge: acc <= acc + prod(step), step <= step + 1.
  - On the edge where step == len-1: do the last MAC and move to DONE.
- prod(k) is computed combinationally:
  - zero-extend x[k] to bw+1 bits and treat it as signed;
  - multiply by the signed w[k];
  - sign-extend the result to psum_bw bits.
  - Accumulation wraps modulo 2^psum_bw, with no saturation or overflow flag.
- DONE:
  - out_valid = 1 and psum_out = acc; both stay stable until the handshake.
  - On an edge with out_ready: move to IDLE and set out_valid = 0.
  - in_ready stays 0 in DONE, so a new vector is never accepted on the out handshake edge.
- Latency: out_valid rises exactly len cycles after the accepting edge. Throughput is one vector per len+2 cycles when out_ready is held high.
- Operand registers are frozen in RUN and DONE; x_vec, w_vec and psum_in may change freely after acceptance.
- Reset mid-RUN or mid-DONE aborts the vector: the result is discarded and everything returns to the reset values on the next edge.
- len = 1: RUN lasts one cycle.
- out_ready held high while in IDLE or RUN has no effect.

Decomposition:
- Shared header/package mac_seq_defs holds:
  - state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - lane-slice helper widths;
  - default bw and psum_bw.
- One sub-module: mac_core, purely combinational, with inputs a (unsigned bw), b (signed bw) and c (psum_bw), and output out = a*b + c. It implements the width rules above.
- mac_seq_ctrl owns the FSM, step counter, operand and accumulator registers, and both handshakes.

Test Plan:
- Basic dot product: x=[1,2,3,4], w=[1,1,1,1], psum_in=0 -> out_valid exactly 4 cycles after accept, psum_out = 10.
- Signed extremes: x=[15,15,15,15], w=[-8,-8,-8,-8], psum_in=0 -> psum_out = -480 (16'hFE20). Also x=[15,0,0,0], w=[7,0,0,0], psum_in=-5 -> 100.
- Wrap-around: psum_in=16'h7FFF, x=[1,0,0,0], w=[1,0,0,0] -> psum_out = 16'h8000, with no other flag.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE -> psum_out stable, in_ready=0, and in_valid pulses are ignored.
  - Assert out_ready -> IDLE next cycle with in_ready=1.
- Mid-operation reset: assert reset while step=2 -> next cycle state IDLE, out_valid=0, busy=0, acc=0. No stale result ever appears.
- Back-to-back: two vectors with in_valid and out_ready held high -> results 10 and -480 in order, spaced 6 cycles apart (len+2).
